// File: rtl/xbus_arb.sv
// rtl/xbus_arb.sv - two-master xbus arbiter with in-order read response routing
// Optional feature macro: XBUS_ARB_FIXED_PRIO_EN (m0 strict priority instead of round-robin)
module xbus_arb #(
  parameter int RESP_FIFO_DEPTH = 4
) (
  input  logic                                 clk_i,
  input  logic                                 arst_n_i,
  input  logic                                 m0_req_i,
  input  logic                                 m0_we_i,
  input  logic [31:0]                          m0_addr_bi,
  input  logic [3:0]                           m0_be_bi,
  input  logic [31:0]                          m0_wdata_bi,
  output logic                                 m0_ack_o,
  output logic                                 m0_resp_o,
  output logic [31:0]                          m0_rdata_bo,
  input  logic                                 m1_req_i,
  input  logic                                 m1_we_i,
  input  logic [31:0]                          m1_addr_bi,
  input  logic [3:0]                           m1_be_bi,
  input  logic [31:0]                          m1_wdata_bi,
  output logic                                 m1_ack_o,
  output logic                                 m1_resp_o,
  output logic [31:0]                          m1_rdata_bo,
  output logic                                 s_req_o,
  output logic                                 s_we_o,
  output logic [31:0]                          s_addr_bo,
  output logic [3:0]                           s_be_bo,
  output logic [31:0]                          s_wdata_bo,
  input  logic                                 s_ack_i,
  input  logic                                 s_resp_i,
  input  logic [31:0]                          s_rdata_bi,
  output logic [$clog2(RESP_FIFO_DEPTH+1)-1:0] outstanding_o,
  output logic                                 err_o
);

  localparam int PW = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(RESP_FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RESP_FIFO_DEPTH);

  // Tracking FIFO state: one master-ID bit per outstanding read
  logic [RESP_FIFO_DEPTH-1:0] r_fifo;
  logic [PW-1:0]              r_wr_ptr;
  logic [PW-1:0]              r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic                       r_full;
  logic                       r_err;

  logic [1:0]    w_req;
  logic [1:0]    w_we;
  logic          w_any_req;
  logic          w_gnt_id;
  logic          w_oth_id;
  logic          w_gnt_stall;
  logic          w_fwd_valid;
  logic          w_fwd_id;
  logic          w_fwd_we;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_orphan;
  logic          w_empty;
  logic          w_head_id;
  logic [CW-1:0] w_count_nxt;

  assign w_req     = {m1_req_i, m0_req_i};
  assign w_we      = {m1_we_i, m0_we_i};
  assign w_any_req = |w_req;

`ifndef XBUS_ARB_FIXED_PRIO_EN
  logic r_last_grant;

  // Remember which master completed the last accepted transfer (round-robin history)
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_fwd_id;
    end
  end
`endif

  // Pick the granted master: single requester wins, contention resolved by priority scheme
  always_comb begin
    w_gnt_id = 1'b0;
    if (w_req == 2'b11) begin
`ifdef XBUS_ARB_FIXED_PRIO_EN
      w_gnt_id = 1'b0;
`else
      w_gnt_id = ~r_last_grant;
`endif
    end else if (w_req[1]) begin
      w_gnt_id = 1'b1;
    end
  end

  assign w_oth_id    = ~w_gnt_id;
  // A read cannot be tracked while the FIFO is full; the registered flag keeps this off the pop path
  assign w_gnt_stall = w_any_req & ~w_we[w_gnt_id] & r_full;

  // Decide which master (if any) reaches the target; a stalled read yields to the other master's write
  always_comb begin
    w_fwd_valid = 1'b0;
    w_fwd_id    = w_gnt_id;
    if (w_any_req) begin
      if (!w_gnt_stall) begin
        w_fwd_valid = 1'b1;
      end else if (w_req[w_oth_id] && w_we[w_oth_id]) begin
        w_fwd_valid = 1'b1;
        w_fwd_id    = w_oth_id;
      end
    end
  end

  assign w_fwd_we   = w_fwd_valid & w_we[w_fwd_id];

  assign s_req_o    = w_fwd_valid;
  assign s_we_o     = w_fwd_we;
  assign s_addr_bo  = !w_fwd_valid ? 32'h0 : (w_fwd_id ? m1_addr_bi  : m0_addr_bi);
  assign s_be_bo    = !w_fwd_valid ? 4'h0  : (w_fwd_id ? m1_be_bi    : m0_be_bi);
  assign s_wdata_bo = !w_fwd_valid ? 32'h0 : (w_fwd_id ? m1_wdata_bi : m0_wdata_bi);

  assign w_accept   = w_fwd_valid & s_ack_i;
  assign m0_ack_o   = w_accept & ~w_fwd_id;
  assign m1_ack_o   = w_accept &  w_fwd_id;

  // Only reads produce a response, so only reads are tracked
  assign w_push     = w_accept & ~w_fwd_we;
  assign w_empty    = (r_count == '0);
  assign w_pop      = s_resp_i & ~w_empty;
  assign w_orphan   = s_resp_i &  w_empty;
  assign w_head_id  = r_fifo[r_rd_ptr];

  assign m0_resp_o   = w_pop & ~w_head_id;
  assign m1_resp_o   = w_pop &  w_head_id;
  assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : 32'h0;
  assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : 32'h0;

  // Next occupancy: simultaneous push and pop leave the count unchanged
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Tracking FIFO storage, pointers, count and registered full flag
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_fifo   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_fwd_id;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
    end
  end

  // Sticky flag for a response that had no matching read
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_err <= 1'b0;
    end else if (w_orphan) begin
      r_err <= 1'b1;
    end
  end

  assign outstanding_o = r_count;
  assign err_o         = r_err;

endmodule

// File: doc/xbus_arb.md
# xbus_arb

Two-master arbiter for the split-transaction MemSplit32-style xbus. It shares one xbus target, such as the GPIO/CSR block at 0x80000000, between two requesters, for example a tile's xbus port and the udm debug bus. The arbiter forwards one request per cycle with zero added latency. It records the issuing master of every accepted read in an in-order tracking FIFO, so each read response is routed back to the master that issued it.

## Interface
- RESP_FIFO_DEPTH, 4: maximum outstanding reads tracked; power of two, ≥2.
- clk_i  in  1  clock.
- arst_n_i  in  1  asynchronous reset, active-low.
- mN_req_i  in  1  master N request (N = 0, 1).
- mN_we_i  in  1  master N write enable.
- mN_addr_bi  in  32  master N address.
- mN_be_bi  in  4  master N byte enables.
- mN_wdata_bi  in  32  master N write data.
- mN_ack_o  out  1  master N request accepted this cycle.
- mN_resp_o  out  1  master N read response valid.
- mN_rdata_bo  out  32  master N read data.
- s_req_o, s_we_o, s_addr_bo[31:0], s_be_bo[3:0], s_wdata_bo[31:0]  out  target request.
- s_ack_i  in  1  target accepted request.
- s_resp_i  in  1  target read response valid.
- s_rdata_bi  in  32  target read data.
- outstanding_o  out  $clog2(RESP_FIFO_DEPTH+1)  reads in flight.
- err_o  out  1  sticky orphan-response flag.

## Operation
- Grant (combinational):
  - Exactly one master is granted when any requests.
  - Only one requesting: that master wins.
  - Both requesting: round-robin; the master not granted last wins.
- last_grant register:
  - Updated only on an accepted transfer (s_req_o & s_ack_i).
  - Reset value 1, so m0 wins the first contention.
- Stall rule: a granted read is blocked when the tracking FIFO is full, using the registered full flag.
  - s_req_o stays 0 even if a pop occurs in the same cycle.
  - Writes are never blocked; they generate no response and need no tracking.
- Blocked master: when the granted master is stalled and the other master has a write pending, the other master's write is forwarded instead.
- Forwarding: s_* request fields mux from the forwarded master; when no request is forwarded they are driven to 0.
- Ack: mN_ack_o = s_ack_i & s_req_o & (forwarded master == N).
- Push: every accepted read pushes the master ID (1 bit) into the FIFO.
- Pop and route: every s_resp_i pops the FIFO head.
  - mID_resp_o = 1 and mID_rdata_bo = s_rdata_bi for the head ID.
  - The other master sees resp 0 and rdata 0.
- Simultaneous push and pop: both take effect; the count is unchanged.
- Orphan response: s_resp_i with the FIFO empty is dropped (no master resp), and err_o is set to 1 until reset.
- outstanding_o equals the FIFO count; wrap-around uses log2(DEPTH)-bit pointers plus a separate count register.

## Timing
- Request path is fully combinational, with zero added latency; accept occurs in the same cycle as s_ack_i.
- Response path is combinational; mN_resp_o asserts in the same cycle as s_resp_i.
- FIFO, last_grant and err_o update on the rising edge of clk_i.
- Reset values:
  - FIFO empty, outstanding_o = 0, err_o = 0, last_grant = 1.
  - All ack/resp/rdata outputs are 0 when their inputs are idle.
- Reset mid-operation: the FIFO is cleared asynchronously and all in-flight reads are forgotten; responses arriving afterward are orphans and set err_o.
- Masters must hold request fields stable until they see ack.

## Configuration
- XBUS_ARB_FIXED_PRIO_EN:
  - Defined: m0 has strict priority whenever both masters request, and last_grant is not used.
  - Undefined: round-robin as above.
  - Stall and write-bypass rules are identical in both modes.

## Test plan
- Single read: m0 reads 0x80000004, target acks and returns resp with 0xA5A5_0001 two cycles later.
  - Required: m0_ack_o in the same cycle, m0_resp_o = 1 with rdata 0xA5A5_0001, m1_resp_o = 0, outstanding_o 1→0.
- Contention: m0 and m1 both hold read requests for 4 cycles, with the target acking every cycle.
  - Required: grants alternate m0, m1, m0, m1 (m0 first after reset).
  - With XBUS_ARB_FIXED_PRIO_EN: m0 is granted four times.
- Interleaved routing: sequence m1 read, m0 read, m1 write 0x0000_00FF to 0x80000000; the target responds 0x11 then 0x22.
  - Required: m1 gets 0x11, m0 gets 0x22, and the write produces no response.
- Full FIFO: issue 4 m0 reads with no responses, then a 5th m0 read alongside an m1 write.
  - Required: the 5th read is stalled (no ack), the m1 write is forwarded and acked.
  - Required: after one s_resp_i, the 5th read is accepted on the next cycle.
- Orphan: pulse s_resp_i with the FIFO empty.
  - Required: no mN_resp_o, err_o = 1, and err_o stays set until arst_n_i goes low.
- Async reset with 3 reads outstanding: assert arst_n_i low mid-cycle.
  - Required: outstanding_o = 0 immediately, err_o = 0.
  - Required: a subsequent s_resp_i sets err_o.
